// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 round engine.
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        StIdle,
        StKeywait,
        StSub,
        StSubcap,
        StDone
    } state_t;

    localparam int unsigned NR_DEFAULT = 10;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i sits at bits [127-8i -: 8]; row r of column c is byte 4c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// Load/readback and keyexpansion handshake bundle for the round engine.
interface aes_round_engine_if;
    logic         load;
    logic [127:0] plaintext;
    logic [127:0] roundkey;
    logic         roundkey_vld;
    logic [3:0]   round;
    logic [127:0] cyphertext;
    logic         done;

    modport master (
        output load, plaintext, roundkey, roundkey_vld,
        input  round, cyphertext, done
    );

    modport slave (
        input  load, plaintext, roundkey, roundkey_vld,
        output round, cyphertext, done
    );
endinterface

// File: rtl/aes_mix_column.sv
// MixColumns on one 32-bit column (byte 0 in the top bits).
module aes_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    byte_t a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col;

    assign mixed = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
endmodule

// File: rtl/aes_sbox.sv
// Shared synchronous AES S-box ROM with a configurable read latency (LAT >= 1).
module aes_sbox
    import aes_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic  clk,
    input  byte_t addr,
    output byte_t data
);
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    byte_t pipe_q [LAT];

    always_ff @(posedge clk) begin
        pipe_q[0] <= SBOX_ROM[8 * (255 - int'(addr)) +: 8];
        for (int i = 1; i < int'(LAT); i++) begin
            pipe_q[i] <= pipe_q[i - 1];
        end
    end

    assign data = pipe_q[LAT - 1];
endmodule

// File: rtl/aes_round_engine.sv
// AES-128 encryption sequencer: steps keyexpansion's round counter and applies
// AddRoundKey / SubBytes / ShiftRows / MixColumns for NR rounds.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned NR       = NR_DEFAULT,
    parameter int unsigned SBOX_LAT = 1
) (
    input logic               int_osc,
    input logic               reset,
    aes_round_engine_if.slave bus
);
    localparam int unsigned CntW      = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [3:0]  LastRound = 4'(NR);

    state_t          fsm_q, fsm_d;
    logic [127:0]    state_q, state_d;
    logic [127:0]    ct_q, ct_d;
    logic [3:0]      round_q, round_d;
    logic            done_q, done_d;
    logic [CntW-1:0] sub_cnt_q, sub_cnt_d;
    logic            was_keywait_q;
    logic [127:0]    ark, sb, shifted, mixed;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox #(.LAT(SBOX_LAT)) u_sbox (
            .clk  (int_osc),
            .addr (state_q[127 - 8 * i -: 8]),
            .data (sb[127 - 8 * i -: 8])
        );
    end

    assign shifted = shift_rows(sb);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mix_column u_mix (
            .col   (shifted[127 - 32 * c -: 32]),
            .mixed (mixed[127 - 32 * c -: 32])
        );
    end

    assign ark = state_q ^ bus.roundkey;

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        ct_d      = ct_q;
        round_d   = round_q;
        done_d    = done_q;
        sub_cnt_d = sub_cnt_q;
        case (fsm_q)
            StIdle: begin
                if (bus.load) begin
                    state_d = bus.plaintext;
                    round_d = '0;
                    done_d  = 1'b0;
                    fsm_d   = StKeywait;
                end
            end
            // First KEYWAIT cycle ignores vld: it may still be left over from the last round.
            StKeywait: begin
                if (was_keywait_q && bus.roundkey_vld) begin
                    state_d = ark;
                    if (round_q == LastRound) begin
                        ct_d   = ark;
                        done_d = 1'b1;
                        fsm_d  = StDone;
                    end else begin
                        round_d   = round_q + 4'd1;
                        sub_cnt_d = '0;
                        fsm_d     = StSub;
                    end
                end
            end
            StSub: begin
                if (sub_cnt_q == CntW'(SBOX_LAT - 1)) fsm_d = StSubcap;
                else sub_cnt_d = sub_cnt_q + CntW'(1);
            end
            StSubcap: begin
                state_d = (round_q == LastRound) ? shifted : mixed;
                fsm_d   = StKeywait;
            end
            StDone: begin
                if (!bus.load) fsm_d = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            fsm_q         <= StIdle;
            state_q       <= '0;
            ct_q          <= '0;
            round_q       <= '0;
            done_q        <= 1'b0;
            sub_cnt_q     <= '0;
            was_keywait_q <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            ct_q          <= ct_d;
            round_q       <= round_d;
            done_q        <= done_d;
            sub_cnt_q     <= sub_cnt_d;
            was_keywait_q <= (fsm_q == StKeywait);
        end
    end

    assign bus.round      = round_q;
    assign bus.cyphertext = ct_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine with a byte-level AES-128 reference and
// a behavioural keyexpansion model.
module tb_aes_round_engine;
    localparam int NR = 10;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_engine_if bus ();

    aes_round_engine #(.NR(NR), .SBOX_LAT(1)) dut (
        .int_osc (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sbox_ref [256];
    logic [127:0] rk_tab [0:10];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]}
                    ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk_tab[0][127 - 8 * i -: 8];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_ref[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4 * c + row] = s[4 * ((c + row) % 4) + row];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                if (r != NR) begin
                    s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tab[r][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- keyexpansion model ----------------
    // vld rises one cycle after round changes; stale_mode holds it high always,
    // hold_mode keeps it low for 5 extra cycles in round 3's key wait.
    bit          stale_mode = 1'b0;
    bit          hold_mode = 1'b0;
    int unsigned kc = 100;
    logic [3:0]  last_round = 4'd0;

    always @(negedge clk) begin
        if (bus.round != last_round) begin
            last_round = bus.round;
            kc = 0;
        end else if (kc < 100) begin
            kc++;
        end
        bus.roundkey = (bus.round <= 4'd10) ? rk_tab[bus.round] : 128'h0;
        bus.roundkey_vld = stale_mode ||
            (kc >= 1 && !(hold_mode && bus.round == 4'd3 && kc >= 3 && kc <= 7));
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] ct;
        int unsigned  start;
        int unsigned  lat;
    } exp_t;

    exp_t sb_q [$];
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.done && !done_prev) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done rose, got 1 required 0 (nothing pending)");
            end else begin
                e = sb_q.pop_front();
                check("cyphertext", bus.cyphertext, e.ct);
                check("latency", 128'(cyc - e.start), 128'(e.lat));
                check("round_at_done", 128'(bus.round), 128'(NR));
            end
        end
        done_prev = bus.done;
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL done_timeout: got done=0 after 200 cycles, required 1");
            sb_q.delete();
        end
    endtask

    task automatic start_enc(input logic [127:0] pt, input logic [127:0] key,
                             input int unsigned extra);
        exp_t e;
        expand_key(key);
        e.ct = aes_ref(pt);
        @(negedge clk);
        bus.plaintext = pt;
        bus.load = 1'b1;
        e.start = cyc + 1;
        e.lat = 2 + 4 * NR + extra;
        sb_q.push_back(e);
    endtask

    task automatic run_enc(input logic [127:0] pt, input logic [127:0] key,
                           input int unsigned extra, input bit keep_load);
        bit ok;
        logic [127:0] exp_ct;
        start_enc(pt, key, extra);
        exp_ct = aes_ref(pt);
        @(negedge clk);
        check("round_at_start", 128'(bus.round), 128'd0);
        if (!keep_load) bus.load = 1'b0;
        repeat (2) @(negedge clk);
        check("round_after_ark0", 128'(bus.round), 128'd1);
        wait_done(ok);
        if (ok && keep_load) begin
            repeat (10) @(negedge clk);
            check("done_load_high", 128'(bus.done), 128'd1);
            check("round_load_high", 128'(bus.round), 128'(NR));
            check("ct_load_high", bus.cyphertext, exp_ct);
            bus.load = 1'b0;
            repeat (3) @(negedge clk);
            check("done_held_idle", 128'(bus.done), 128'd1);
        end
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [127:0] pt, key;
        int unsigned mode;
        bus.load = 1'b0;
        bus.plaintext = '0;
        build_sbox();

        repeat (2) @(negedge clk);
        check("reset_round", 128'(bus.round), 128'd0);
        check("reset_done", 128'(bus.done), 128'd0);
        check("reset_ct", bus.cyphertext, 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_enc(FIPS_PT, FIPS_KEY, 0, 1'b0);
        check("fips_ct", bus.cyphertext, FIPS_CT);

        hold_mode = 1'b1;
        run_enc(FIPS_PT, FIPS_KEY, 5, 1'b0);
        hold_mode = 1'b0;
        check("fips_ct_hold", bus.cyphertext, FIPS_CT);

        stale_mode = 1'b1;
        run_enc(FIPS_PT, FIPS_KEY, 0, 1'b0);
        stale_mode = 1'b0;

        // Reset pulse in the middle of round 6.
        start_enc(FIPS_PT, FIPS_KEY, 0);
        @(negedge clk);
        bus.load = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.round == 4'd6) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL round6_timeout: got round %0d, required 6", bus.round);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midreset_round", 128'(bus.round), 128'd0);
        check("midreset_done", 128'(bus.done), 128'd0);
        check("midreset_ct", bus.cyphertext, 128'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_enc(FIPS_PT, FIPS_KEY, 0, 1'b0);

        // Load held through DONE, then a toggled second run.
        run_enc(FIPS_PT, FIPS_KEY, 0, 1'b1);
        run_enc(FIPS_PT, FIPS_KEY, 0, 1'b0);
        check("fips_ct_rerun", bus.cyphertext, FIPS_CT);

        for (int n = 0; n < 5; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            mode = $urandom_range(0, 2);
            stale_mode = (mode == 1);
            hold_mode  = (mode == 2);
            run_enc(pt, key, (mode == 2) ? 5 : 0, 1'b0);
        end
        stale_mode = 1'b0;
        hold_mode = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
